// File: rtl/iir_stream_sink.sv
// Output FIFO that collects filtered samples from an IIR stage and hands them
// to a ready/valid consumer. It counts accepted samples and flags overflow drops.
module iir_stream_sink #(
   parameter int DW    = 12,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DW-1:0]            din,
   input  logic                     vin,
   output logic [DW-1:0]            dout,
   output logic                     vout,
   input  logic                     rdy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf,
   input  logic                     ovf_clr,
   output logic [15:0]              smp_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DW-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          vout_q, vout_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   smp_cnt_q, smp_cnt_d;
   logic [DW-1:0] dout_q, dout_d;

   logic full;
   logic pop;
   logic push;
   logic drop;

   always_comb begin
      full = (level_q == LW'(DEPTH));
      pop  = vout_q & rdy;
      push = vin & (~full | pop);
      drop = vin & full & ~pop;

      wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      smp_cnt_d = push ? smp_cnt_q + 16'd1 : smp_cnt_q;

      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      vout_d = (level_d != '0);

      // Set wins over clear when a drop coincides with ovf_clr.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      // The head register is loaded from the entry the read pointer will point
      // at next; if that entry is being written this very edge, take din so a
      // sample reaches dout one cycle after the push without a comb path.
      dout_d = dout_q;
      if (vout_d) begin
         if (push && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = din;
         end else begin
            dout_d = mem[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         vout_q    <= 1'b0;
         ovf_q     <= 1'b0;
         smp_cnt_q <= '0;
         dout_q    <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         vout_q    <= vout_d;
         ovf_q     <= ovf_d;
         smp_cnt_q <= smp_cnt_d;
         dout_q    <= dout_d;
      end
   end

   assign dout    = dout_q;
   assign vout    = vout_q;
   assign level   = level_q;
   assign ovf     = ovf_q;
   assign smp_cnt = smp_cnt_q;

endmodule

// File: tb/tb_iir_stream_sink.sv
// Self-checking bench for iir_stream_sink: queue-based reference model with
// a vector table for basic flow plus hand-written overflow/stream/reset runs.
module tb_iir_stream_sink;

   localparam int DW    = 12;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   logic [DW-1:0] din;
   logic          vin;
   logic [DW-1:0] dout;
   logic          vout;
   logic          rdy;
   logic [LW-1:0] level;
   logic          ovf;
   logic          ovf_clr;
   logic [15:0]   smp_cnt;

   iir_stream_sink #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .din     (din),
      .vin     (vin),
      .dout    (dout),
      .vout    (vout),
      .rdy     (rdy),
      .level   (level),
      .ovf     (ovf),
      .ovf_clr (ovf_clr),
      .smp_cnt (smp_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [DW-1:0] sb[$];
   logic [15:0]   m_cnt;
   logic          m_ovf;

   typedef struct {
      logic          vin;
      logic [DW-1:0] din;
      logic          rdy;
      logic          clr;
      logic          e_vout;
      int            e_level;
      logic          chk_dout;
      logic [DW-1:0] e_dout;
      logic          e_ovf;
      int            e_cnt;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_cnt = '0;
      m_ovf = 1'b0;
   endtask

   // One clock cycle: advance the model with the current inputs, clock the
   // DUT, then compare every observable output against the model.
   task automatic step();
      bit m_pop;
      bit m_push;
      m_pop  = (sb.size() != 0) && rdy;
      m_push = vin && ((sb.size() < DEPTH) || m_pop);
      if (m_pop) void'(sb.pop_front());
      if (m_push) begin
         sb.push_back(din);
         m_cnt = m_cnt + 16'd1;
      end
      if (vin && !m_push) m_ovf = 1'b1;
      else if (ovf_clr)  m_ovf = 1'b0;
      @(posedge clk);
      #1;
      chk("sb_level", 32'(level), 32'(sb.size()));
      chk("sb_vout", 32'(vout), 32'(sb.size() != 0));
      chk("sb_ovf", 32'(ovf), 32'(m_ovf));
      chk("sb_cnt", 32'(smp_cnt), 32'(m_cnt));
      if (sb.size() != 0) chk("sb_dout", 32'(dout), 32'(sb[0]));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      vin = 1'b1; din = 12'hABC; rdy = 1'b1; ovf_clr = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_vout", 32'(vout), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_cnt", 32'(smp_cnt), 0);
      rst = 1'b0;
      vin = 1'b0; din = '0; rdy = 1'b0; ovf_clr = 1'b0;
   endtask

   task automatic set_in(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
      vin = v; din = d; rdy = r; ovf_clr = c;
   endtask

   initial begin
      logic [DW-1:0] d;
      logic [DW-1:0] popped;

      rst = 1'b0;
      set_in(0, '0, 0, 0);
      model_reset();

      //         vin din      rdy clr  vout lvl chkd dout    ovf cnt
      vecs[0] = '{1, 12'h7FF, 0, 0,   1,   1,  1, 12'h7FF, 0,  1};
      vecs[1] = '{0, 12'h000, 1, 0,   0,   0,  0, 12'h000, 0,  1};
      vecs[2] = '{1, 12'h100, 1, 0,   1,   1,  1, 12'h100, 0,  2};
      vecs[3] = '{1, 12'h200, 0, 0,   1,   2,  1, 12'h100, 0,  3};
      vecs[4] = '{0, 12'h000, 0, 0,   1,   2,  1, 12'h100, 0,  3};
      vecs[5] = '{1, 12'h300, 1, 0,   1,   2,  1, 12'h200, 0,  4};
      vecs[6] = '{0, 12'h000, 1, 0,   1,   1,  1, 12'h300, 0,  4};
      vecs[7] = '{0, 12'h000, 1, 0,   0,   0,  0, 12'h000, 0,  4};
      vecs[8] = '{0, 12'h000, 1, 1,   0,   0,  0, 12'h000, 0,  4};

      @(negedge clk);
      do_reset();

      // Basic push/pop flow, including push into empty with rdy=1
      for (int i = 0; i < 9; i++) begin
         set_in(vecs[i].vin, vecs[i].din, vecs[i].rdy, vecs[i].clr);
         step();
         chk("vec_vout", 32'(vout), 32'(vecs[i].e_vout));
         chk("vec_level", 32'(level), 32'(vecs[i].e_level));
         chk("vec_ovf", 32'(ovf), 32'(vecs[i].e_ovf));
         chk("vec_cnt", 32'(smp_cnt), 32'(vecs[i].e_cnt));
         if (vecs[i].chk_dout) chk("vec_dout", 32'(dout), 32'(vecs[i].e_dout));
         $display("vec %0d: vin=%0d din=%03h rdy=%0d -> vout=%0d dout=%03h level=%0d",
                  i, vecs[i].vin, vecs[i].din, vecs[i].rdy, vout, dout, level);
      end

      // Fill to full, overflow drop, then drain in order
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         set_in(1, DW'(i), 0, 0);
         step();
      end
      chk("full_level", 32'(level), 16);
      chk("full_ovf", 32'(ovf), 0);
      set_in(1, 12'h011, 0, 0);
      step();
      chk("drop_ovf", 32'(ovf), 1);
      chk("drop_level", 32'(level), 16);
      chk("drop_cnt", 32'(smp_cnt), 16);
      for (int i = 1; i <= 16; i++) begin
         set_in(0, '0, 1, 0);
         popped = dout;
         chk("drain_order", 32'(popped), 32'(i));
         step();
         $display("drain %0d: popped %03h level=%0d", i, popped, level);
      end
      chk("drain_empty", 32'(vout), 0);

      // Full with simultaneous push and pop
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         set_in(1, DW'(i), 0, 0);
         step();
      end
      set_in(1, 12'h800, 1, 0);
      step();
      chk("fullpp_level", 32'(level), 16);
      chk("fullpp_ovf", 32'(ovf), 0);
      chk("fullpp_cnt", 32'(smp_cnt), 17);
      chk("fullpp_head", 32'(dout), 2);

      // Overflow drop coinciding with ovf_clr: set wins, then plain clear
      set_in(1, 12'h0AA, 0, 0);
      step();
      chk("ovf_set", 32'(ovf), 1);
      set_in(1, 12'h0BB, 0, 1);
      step();
      chk("ovf_set_wins", 32'(ovf), 1);
      set_in(0, '0, 0, 1);
      step();
      chk("ovf_cleared", 32'(ovf), 0);
      for (int i = 0; i < 16; i++) begin
         set_in(0, '0, 1, 0);
         step();
      end
      chk("fullpp_drained", 32'(level), 0);

      // Continuous streaming across pointer wrap
      do_reset();
      d = 12'hFF0;
      for (int i = 0; i < 40; i++) begin
         set_in(1, d, 1, 0);
         step();
         chk("stream_level", 32'(level), 1);
         chk("stream_dout", 32'(dout), 32'(d));
         d = d + 12'd1;
      end
      set_in(0, '0, 1, 0);
      step();
      chk("stream_end", 32'(level), 0);

      // Asynchronous reset mid-operation
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_in(1, DW'(12'h050 + i), 0, 0);
         step();
      end
      chk("pre_rst_level", 32'(level), 5);
      #2;
      rst = 1'b1;
      #1;
      chk("async_vout", 32'(vout), 0);
      chk("async_level", 32'(level), 0);
      chk("async_cnt", 32'(smp_cnt), 0);
      chk("async_ovf", 32'(ovf), 0);
      model_reset();
      set_in(1, 12'h3C3, 1, 1);
      @(posedge clk);
      #1;
      chk("rst_ignore_level", 32'(level), 0);
      rst = 1'b0;
      set_in(1, 12'h123, 0, 0);
      step();
      chk("post_rst_dout", 32'(dout), 32'h123);
      chk("post_rst_vout", 32'(vout), 1);
      chk("post_rst_cnt", 32'(smp_cnt), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
